// File: rtl/i8085_pkg.sv
// Shared types for the 8085 bus-cycle sequencer: machine-cycle kinds,
// sequencer states, one-hot T-state codes and the status-pin encoding.
package i8085_pkg;

    typedef enum logic [2:0] {
        MC_OF   = 3'd0,
        MC_MR   = 3'd1,
        MC_MW   = 3'd2,
        MC_IOR  = 3'd3,
        MC_IOW  = 3'd4,
        MC_INTA = 3'd5,
        MC_HALT = 3'd6
    } mc_type_t;

    typedef enum logic [3:0] {
        TS_RESET = 4'd0,
        TS_T1    = 4'd1,
        TS_T2    = 4'd2,
        TS_TW    = 4'd3,
        TS_T3    = 4'd4,
        TS_T4    = 4'd5,
        TS_T5    = 4'd6,
        TS_T6    = 4'd7,
        TS_HALT  = 4'd8
    } tstate_e;

    // One-hot T-state word seen by the decoder: {T1,T2,T3,T4,T5,T6,TRESET}
    localparam logic [6:0] TOH_T1    = 7'b100_0000;
    localparam logic [6:0] TOH_T2    = 7'b010_0000;
    localparam logic [6:0] TOH_T3    = 7'b001_0000;
    localparam logic [6:0] TOH_T4    = 7'b000_1000;
    localparam logic [6:0] TOH_T5    = 7'b000_0100;
    localparam logic [6:0] TOH_T6    = 7'b000_0010;
    localparam logic [6:0] TOH_RESET = 7'b000_0001;

    // {IO/M, S1, S0} driven for each machine-cycle kind
    function automatic logic [2:0] status_code(input mc_type_t t);
        logic [2:0] code;
        code = 3'b000;
        case (t)
            MC_OF:   code = 3'b011;
            MC_MR:   code = 3'b010;
            MC_MW:   code = 3'b001;
            MC_IOR:  code = 3'b110;
            MC_IOW:  code = 3'b101;
            MC_INTA: code = 3'b111;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Wait states keep reporting T2; halt reports the idle code
    function automatic logic [6:0] tstate_onehot(input tstate_e s);
        logic [6:0] oh;
        oh = TOH_RESET;
        case (s)
            TS_T1:   oh = TOH_T1;
            TS_T2:   oh = TOH_T2;
            TS_TW:   oh = TOH_T2;
            TS_T3:   oh = TOH_T3;
            TS_T4:   oh = TOH_T4;
            TS_T5:   oh = TOH_T5;
            TS_T6:   oh = TOH_T6;
            default: oh = TOH_RESET;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bus_status_enc.sv
// Combinational decode of a machine-cycle kind into status pins and
// read/write strobe class.
module bus_status_enc
    import i8085_pkg::*;
(
    input  mc_type_t   mc_type_i,
    output logic [2:0] status_o,
    output logic       is_read_o,
    output logic       is_write_o
);

    // Status pins plus which strobe (if any) the cycle uses
    always_comb begin
        status_o   = status_code(mc_type_i);
        is_read_o  = 1'b0;
        is_write_o = 1'b0;
        case (mc_type_i)
            MC_OF, MC_MR, MC_IOR, MC_INTA: is_read_o  = 1'b1;
            MC_MW, MC_IOW:                 is_write_o = 1'b1;
            default: begin
                is_read_o  = 1'b0;
                is_write_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085 external bus machine-cycle sequencer. Steps one machine cycle per
// accepted request through T1..T6/TW, drives the bus pins and captures
// opcode / read data for the instruction decoder.
module bus_cycle_ctrl
    import i8085_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        phi1,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  mc_type_t    req_type,
    input  logic        req_long,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        halt_wake,
    input  logic        ready,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic [7:0]  a_hi,
    output logic        ale,
    output logic        rdn,
    output logic        wrn,
    output logic        iomn,
    output logic        s1,
    output logic        s0,
    output logic [7:0]  rdata,
    output logic        done,
    output logic [7:0]  instr,
    output logic        instr_load,
    output logic [6:0]  t_state,
    output logic        wait_timeout
);

    localparam int CW = $clog2(MAX_WAIT + 2);
    // With MAX_WAIT = 0 the counter only saturates at all-ones and never flags
    localparam logic [CW-1:0] WAIT_SAT = (MAX_WAIT == 0) ? {CW{1'b1}} : CW'(MAX_WAIT);

    tstate_e       state_q, state_d;
    mc_type_t      type_q;
    logic          long_q, rd_q, wr_q;
    logic [2:0]    status_q;
    logic [7:0]    ad_out_q, a_hi_q, wdata_q;
    logic [7:0]    rdata_q, instr_q;
    logic          done_q, done_d;
    logic          instr_load_q;
    logic          wait_timeout_q, timeout_d;
    logic          req_ready_q, req_ready_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic          accept;
    logic          is_of;
    logic          strobe_phase;
    logic [2:0]    enc_status;
    logic          enc_rd, enc_wr;

    assign accept = req_valid && req_ready_q;
    assign is_of  = (type_q == MC_OF);

    bus_status_enc u_status_enc (
        .mc_type_i  (req_type),
        .status_o   (enc_status),
        .is_read_o  (enc_rd),
        .is_write_o (enc_wr)
    );

    // Sequencer state and wait counter registers
    always_ff @(posedge phi1 or negedge resetn) begin
        if (!resetn) begin
            state_q        <= TS_RESET;
            wait_cnt_q     <= '0;
            req_ready_q    <= 1'b0;
            done_q         <= 1'b0;
            wait_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            req_ready_q    <= req_ready_d;
            done_q         <= done_d;
            wait_timeout_q <= timeout_d;
        end
    end

    // Next state, wait counting and the registered handshake/pulse inputs
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            TS_RESET: if (accept) state_d = TS_T1;
            TS_T1: begin
                wait_cnt_d = '0;
                state_d    = (type_q == MC_HALT) ? TS_HALT : TS_T2;
            end
            TS_T2: begin
                if (ready) begin
                    state_d = TS_T3;
                end else begin
                    state_d    = TS_TW;
                    wait_cnt_d = CW'(1);
                end
            end
            TS_TW: begin
                if (ready) begin
                    state_d    = TS_T3;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_SAT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            TS_T3: begin
                wait_cnt_d = '0;
                if (is_of)       state_d = TS_T4;
                else if (accept) state_d = TS_T1;
                else             state_d = TS_RESET;
            end
            TS_T4: begin
                if (long_q)      state_d = TS_T5;
                else if (accept) state_d = TS_T1;
                else             state_d = TS_RESET;
            end
            TS_T5: state_d = TS_T6;
            TS_T6: state_d = accept ? TS_T1 : TS_RESET;
            TS_HALT: if (halt_wake) state_d = TS_RESET;
            default: state_d = TS_RESET;
        endcase

        // Ready is offered while idle and during the last T-state of a cycle
        req_ready_d = (state_d == TS_RESET) ||
                      (state_d == TS_T3 && !is_of) ||
                      (state_d == TS_T4 && is_of && !long_q) ||
                      (state_d == TS_T6);

        done_d = (state_q == TS_T3 && !is_of) ||
                 (state_q == TS_T4 && !long_q) ||
                 (state_q == TS_T6) ||
                 (state_q == TS_HALT && halt_wake);

        timeout_d = (MAX_WAIT != 0) && (state_d == TS_TW) &&
                    (wait_cnt_d == WAIT_SAT) && (wait_cnt_q != WAIT_SAT);
    end

    // Request latch, address/data bus registers and read capture
    always_ff @(posedge phi1 or negedge resetn) begin
        if (!resetn) begin
            type_q       <= MC_HALT;
            long_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            status_q     <= 3'b000;
            ad_out_q     <= 8'h00;
            a_hi_q       <= 8'h00;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            instr_q      <= 8'h00;
            instr_load_q <= 1'b0;
        end else begin
            instr_load_q <= 1'b0;
            if (accept) begin
                type_q   <= req_type;
                long_q   <= req_long && (req_type == MC_OF);
                rd_q     <= enc_rd;
                wr_q     <= enc_wr;
                status_q <= enc_status;
                ad_out_q <= req_addr[7:0];
                a_hi_q   <= req_addr[15:8];
                wdata_q  <= req_wdata;
            end
            if (state_q == TS_T1 && wr_q) begin
                ad_out_q <= wdata_q;
            end
            if (state_q == TS_T3) begin
                if (rd_q) rdata_q <= ad_in;
                if (type_q == MC_OF || type_q == MC_INTA) begin
                    instr_q      <= ad_in;
                    instr_load_q <= 1'b1;
                end
            end
        end
    end

    // Strobes and bus enables decoded from the current state
    always_comb begin
        strobe_phase = (state_q == TS_T2) || (state_q == TS_TW) || (state_q == TS_T3);
        ale          = (state_q == TS_T1);
        rdn          = !(strobe_phase && rd_q);
        wrn          = !(strobe_phase && wr_q);
        ad_oe        = (state_q == TS_T1) || (strobe_phase && wr_q);
    end

    assign req_ready      = req_ready_q;
    assign ad_out         = ad_out_q;
    assign a_hi           = a_hi_q;
    assign {iomn, s1, s0} = status_q;
    assign rdata          = rdata_q;
    assign done           = done_q;
    assign instr          = instr_q;
    assign instr_load     = instr_load_q;
    assign wait_timeout   = wait_timeout_q;
    assign t_state        = tstate_onehot(state_q);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: each task drives one scenario and
// checks bus pins cycle by cycle against hand-derived values.
module tb_bus_cycle_ctrl;
    import i8085_pkg::*;

    localparam logic [6:0] E_T1 = 7'b1000000;
    localparam logic [6:0] E_T2 = 7'b0100000;
    localparam logic [6:0] E_T3 = 7'b0010000;
    localparam logic [6:0] E_T4 = 7'b0001000;
    localparam logic [6:0] E_T5 = 7'b0000100;
    localparam logic [6:0] E_T6 = 7'b0000010;
    localparam logic [6:0] E_TR = 7'b0000001;

    logic        phi1 = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    mc_type_t    req_type = MC_OF;
    logic        req_long = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        halt_wake = 1'b0;
    logic        ready = 1'b1;
    logic [7:0]  ad_in = 8'h00;
    logic [7:0]  ad_out, a_hi, rdata, instr;
    logic        ad_oe, ale, rdn, wrn, iomn, s1, s0, done, instr_load, wait_timeout;
    logic [6:0]  t_state;
    logic [6:0]  ctl;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl = {ale, rdn, wrn, ad_oe, iomn, s1, s0};

    bus_cycle_ctrl #(.MAX_WAIT(16)) dut (
        .phi1(phi1), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_long(req_long), .req_addr(req_addr), .req_wdata(req_wdata),
        .halt_wake(halt_wake), .ready(ready), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .a_hi(a_hi), .ale(ale), .rdn(rdn), .wrn(wrn), .iomn(iomn), .s1(s1), .s0(s0),
        .rdata(rdata), .done(done), .instr(instr), .instr_load(instr_load),
        .t_state(t_state), .wait_timeout(wait_timeout)
    );

    always #5 phi1 = ~phi1;

    // Pin-level invariants: strobes never overlap, ALE only in T1
    always @(negedge phi1) begin
        if (resetn) begin
            n_cmp++;
            if ((!rdn && !wrn) || (ale && t_state != E_T1)) begin
                n_err++;
                $display("FAIL pin_invariant: rdn=%b wrn=%b ale=%b t_state=%b", rdn, wrn, ale, t_state);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge phi1);
        @(negedge phi1);
    endtask

    task automatic issue(input mc_type_t t, input logic lng, input logic [15:0] a, input logic [7:0] wd);
        req_valid = 1'b1;
        req_type  = t;
        req_long  = lng;
        req_addr  = a;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        n_cmp++;
        if (t_state !== E_TR || ctl !== 7'b0110000) begin
            n_err++;
            $display("FAIL reset_pins: t_state=%b ctl=%b want %b %b", t_state, ctl, E_TR, 7'b0110000);
        end
        n_cmp++;
        if ({ad_out, a_hi, rdata, instr} !== 32'h0 || {done, instr_load, wait_timeout, req_ready} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_regs: bus=%h flags=%b want 0", {ad_out, a_hi, rdata, instr},
                     {done, instr_load, wait_timeout, req_ready});
        end
        resetn = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_opcode_fetch();
        ready = 1'b1;
        ad_in = 8'h3E;
        issue(MC_OF, 1'b0, 16'h1234, 8'h00);
        n_cmp++;
        if (t_state !== E_T1 || ctl !== 7'b1111011 || ad_out !== 8'h34 || a_hi !== 8'h12) begin
            n_err++;
            $display("FAIL of_t1: t=%b ctl=%b ad=%h ahi=%h want %b 1111011 34 12", t_state, ctl, ad_out, a_hi, E_T1);
        end
        step();
        n_cmp++;
        if (t_state !== E_T2 || ctl !== 7'b0010011) begin
            n_err++;
            $display("FAIL of_t2: t=%b ctl=%b want %b 0010011", t_state, ctl, E_T2);
        end
        step();
        n_cmp++;
        if (t_state !== E_T3 || ctl !== 7'b0010011) begin
            n_err++;
            $display("FAIL of_t3: t=%b ctl=%b want %b 0010011", t_state, ctl, E_T3);
        end
        step();
        n_cmp++;
        if (t_state !== E_T4 || ctl !== 7'b0110011 || instr !== 8'h3E || instr_load !== 1'b1 ||
            rdata !== 8'h3E || a_hi !== 8'h12 || req_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL of_t4: t=%b ctl=%b instr=%h ld=%b rd=%h ahi=%h rr=%b done=%b want T4 0110011 3e 1 3e 12 1 0",
                     t_state, ctl, instr, instr_load, rdata, a_hi, req_ready, done);
        end
        step();
        n_cmp++;
        if (t_state !== E_TR || done !== 1'b1 || instr_load !== 1'b0) begin
            n_err++;
            $display("FAIL of_end: t=%b done=%b ld=%b want %b 1 0", t_state, done, instr_load, E_TR);
        end
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL of_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_mem_write_wait();
        ready = 1'b0;
        issue(MC_MW, 1'b0, 16'h20FF, 8'hA5);
        n_cmp++;
        if (t_state !== E_T1 || ctl !== 7'b1111001 || ad_out !== 8'hFF || a_hi !== 8'h20) begin
            n_err++;
            $display("FAIL mw_t1: t=%b ctl=%b ad=%h ahi=%h want T1 1111001 ff 20", t_state, ctl, ad_out, a_hi);
        end
        step();
        n_cmp++;
        if (t_state !== E_T2 || ctl !== 7'b0101001 || ad_out !== 8'hA5) begin
            n_err++;
            $display("FAIL mw_t2: t=%b ctl=%b ad=%h want T2 0101001 a5", t_state, ctl, ad_out);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if (t_state !== E_T2 || ctl !== 7'b0101001 || ad_out !== 8'hA5 || done !== 1'b0) begin
                n_err++;
                $display("FAIL mw_tw%0d: t=%b ctl=%b ad=%h done=%b want T2 0101001 a5 0", i, t_state, ctl, ad_out, done);
            end
        end
        ready = 1'b1;
        step();
        n_cmp++;
        if (t_state !== E_T3 || wrn !== 1'b0 || wait_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL mw_t3: t=%b wrn=%b wto=%b want T3 0 0", t_state, wrn, wait_timeout);
        end
        step();
        n_cmp++;
        if (t_state !== E_TR || done !== 1'b1 || wrn !== 1'b1 || ad_oe !== 1'b0) begin
            n_err++;
            $display("FAIL mw_end: t=%b done=%b wrn=%b oe=%b want TR 1 1 0", t_state, done, wrn, ad_oe);
        end
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL mw_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        ad_in = 8'hCD;
        issue(MC_OF, 1'b1, 16'h0100, 8'h00);
        step();
        step();
        step();
        n_cmp++;
        if (t_state !== E_T4 || instr !== 8'hCD || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL long_t4: t=%b instr=%h rr=%b want T4 cd 0", t_state, instr, req_ready);
        end
        step();
        n_cmp++;
        if (t_state !== E_T5 || ctl !== 7'b0110011 || done !== 1'b0) begin
            n_err++;
            $display("FAIL long_t5: t=%b ctl=%b done=%b want T5 0110011 0", t_state, ctl, done);
        end
        step();
        n_cmp++;
        if (t_state !== E_T6 || req_ready !== 1'b1 || a_hi !== 8'h01) begin
            n_err++;
            $display("FAIL long_t6: t=%b rr=%b ahi=%h want T6 1 01", t_state, req_ready, a_hi);
        end
        ad_in = 8'h5A;
        issue(MC_MR, 1'b0, 16'h3000, 8'h00);
        n_cmp++;
        if (t_state !== E_T1 || done !== 1'b1 || ctl !== 7'b1111010 || a_hi !== 8'h30 || ad_out !== 8'h00) begin
            n_err++;
            $display("FAIL b2b_t1: t=%b done=%b ctl=%b ahi=%h ad=%h want T1 1 1111010 30 00",
                     t_state, done, ctl, a_hi, ad_out);
        end
        step();
        n_cmp++;
        if (t_state !== E_T2 || ctl !== 7'b0010010 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_t2: t=%b ctl=%b done=%b want T2 0010010 0", t_state, ctl, done);
        end
        step();
        step();
        n_cmp++;
        if (t_state !== E_TR || done !== 1'b1 || rdata !== 8'h5A || instr !== 8'hCD || instr_load !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: t=%b done=%b rd=%h instr=%h ld=%b want TR 1 5a cd 0",
                     t_state, done, rdata, instr, instr_load);
        end
    endtask

    task automatic test_io_read();
        ready = 1'b1;
        ad_in = 8'h99;
        issue(MC_IOR, 1'b0, 16'h0042, 8'h00);
        n_cmp++;
        if (ctl !== 7'b1111110 || a_hi !== 8'h00 || ad_out !== 8'h42) begin
            n_err++;
            $display("FAIL ior_t1: ctl=%b ahi=%h ad=%h want 1111110 00 42", ctl, a_hi, ad_out);
        end
        step();
        n_cmp++;
        if (t_state !== E_T2 || ctl !== 7'b0010110) begin
            n_err++;
            $display("FAIL ior_t2: t=%b ctl=%b want T2 0010110", t_state, ctl);
        end
        step();
        step();
        n_cmp++;
        if (done !== 1'b1 || rdata !== 8'h99 || instr !== 8'hCD || instr_load !== 1'b0) begin
            n_err++;
            $display("FAIL ior_end: done=%b rd=%h instr=%h ld=%b want 1 99 cd 0", done, rdata, instr, instr_load);
        end
    endtask

    task automatic test_halt();
        issue(MC_HALT, 1'b0, 16'h5678, 8'h00);
        n_cmp++;
        if (t_state !== E_T1 || ctl !== 7'b1111000) begin
            n_err++;
            $display("FAIL halt_t1: t=%b ctl=%b want T1 1111000", t_state, ctl);
        end
        step();
        n_cmp++;
        if (t_state !== E_TR || ctl !== 7'b0110000 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL halt_enter: t=%b ctl=%b rr=%b want TR 0110000 0", t_state, ctl, req_ready);
        end
        req_valid = 1'b1;
        req_type  = MC_MR;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (t_state !== E_TR || ctl !== 7'b0110000 || req_ready !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL halt_hold%0d: t=%b ctl=%b rr=%b done=%b want TR 0110000 0 0",
                         i, t_state, ctl, req_ready, done);
            end
        end
        req_valid = 1'b0;
        halt_wake = 1'b1;
        step();
        halt_wake = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || req_ready !== 1'b1 || t_state !== E_TR) begin
            n_err++;
            $display("FAIL halt_wake: done=%b rr=%b t=%b want 1 1 TR", done, req_ready, t_state);
        end
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL halt_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_wait_timeout();
        int first_hit;
        int pulses;
        first_hit = 0;
        pulses    = 0;
        ready = 1'b0;
        ad_in = 8'h11;
        issue(MC_MR, 1'b0, 16'h4000, 8'h00);
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (wait_timeout === 1'b1) begin
                pulses++;
                if (first_hit == 0) first_hit = i;
            end
        end
        n_cmp++;
        if (first_hit != 16 || pulses != 1) begin
            n_err++;
            $display("FAIL wait_timeout: first at TW %0d, %0d pulses; want TW 16, 1 pulse", first_hit, pulses);
        end
        n_cmp++;
        if (t_state !== E_T2 || rdn !== 1'b0) begin
            n_err++;
            $display("FAIL wait_hold: t=%b rdn=%b want T2 0", t_state, rdn);
        end
        ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (done !== 1'b1 || rdata !== 8'h11 || wait_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL wait_end: done=%b rd=%h wto=%b want 1 11 0", done, rdata, wait_timeout);
        end
    endtask

    task automatic test_reset_mid_cycle();
        ready = 1'b0;
        issue(MC_MR, 1'b0, 16'hABCD, 8'h00);
        step();
        step();
        n_cmp++;
        if (t_state !== E_T2 || rdn !== 1'b0) begin
            n_err++;
            $display("FAIL abort_tw: t=%b rdn=%b want T2 0", t_state, rdn);
        end
        #1 resetn = 1'b0;
        #1;
        n_cmp++;
        if (t_state !== E_TR || ctl !== 7'b0110000 || {ad_out, a_hi, rdata, instr} !== 32'h0 ||
            req_ready !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_async: t=%b ctl=%b bus=%h rr=%b done=%b want TR 0110000 0 0 0",
                     t_state, ctl, {ad_out, a_hi, rdata, instr}, req_ready, done);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || t_state !== E_TR) begin
            n_err++;
            $display("FAIL abort_no_done: done=%b t=%b want 0 TR", done, t_state);
        end
        ready  = 1'b1;
        resetn = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_recover: rr=%b done=%b want 1 0", req_ready, done);
        end
        ad_in = 8'h76;
        issue(MC_OF, 1'b0, 16'h0055, 8'h00);
        n_cmp++;
        if (t_state !== E_T1 || ctl !== 7'b1111011 || ad_out !== 8'h55 || a_hi !== 8'h00) begin
            n_err++;
            $display("FAIL resume_t1: t=%b ctl=%b ad=%h ahi=%h want T1 1111011 55 00", t_state, ctl, ad_out, a_hi);
        end
        step();
        step();
        step();
        n_cmp++;
        if (t_state !== E_T4 || instr !== 8'h76 || instr_load !== 1'b1) begin
            n_err++;
            $display("FAIL resume_t4: t=%b instr=%h ld=%b want T4 76 1", t_state, instr, instr_load);
        end
        step();
        n_cmp++;
        if (done !== 1'b1 || t_state !== E_TR) begin
            n_err++;
            $display("FAIL resume_done: done=%b t=%b want 1 TR", done, t_state);
        end
    endtask

    initial begin
        test_reset();
        test_opcode_fetch();
        test_mem_write_wait();
        test_back_to_back();
        test_io_read();
        test_halt();
        test_wait_timeout();
        test_reset_mid_cycle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
